// File: rtl/clz_denormalizer.sv
// Restores an operand from a normalized mantissa and its leading-zero count
// with a logical right shift, split across three valid/ready pipeline stages.
module clz_denormalizer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_mant,
  input  logic [CNT_WIDTH-1:0]  i_count,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic                  o_sticky,
  output logic                  o_error,
  output logic                  o_unnorm
);

  // One enable moves every stage at once; bubbles travel with the data.
  logic en;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [3:0]            s1_cnt;
  logic                  s1_sticky;
  logic                  s1_err;
  logic                  s1_unnorm;
  logic [TAG_WIDTH-1:0]  s1_tag;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [1:0]            s2_cnt;
  logic                  s2_sticky;
  logic                  s2_err;
  logic                  s2_unnorm;
  logic [TAG_WIDTH-1:0]  s2_tag;

  logic [DATA_WIDTH-1:0] s1_data_d;
  logic [3:0]            s1_cnt_d;
  logic                  s1_sticky_d;
  logic                  s1_err_d;
  logic                  s1_unnorm_d;

  // Counts of 32 and above flush the whole mantissa here and kill later shifts.
  always_comb begin
    s1_err_d    = i_count[5] & (|i_count[4:0]);
    s1_unnorm_d = ~i_count[5] & ~i_mant[DATA_WIDTH-1];
    s1_data_d   = i_mant;
    s1_sticky_d = 1'b0;
    s1_cnt_d    = i_count[3:0];
    if (i_count[5]) begin
      s1_data_d   = '0;
      s1_sticky_d = |i_mant;
      s1_cnt_d    = 4'd0;
    end else if (i_count[4]) begin
      s1_data_d   = {16'b0, i_mant[31:16]};
      s1_sticky_d = |i_mant[15:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_cnt    <= 4'd0;
      s1_sticky <= 1'b0;
      s1_err    <= 1'b0;
      s1_unnorm <= 1'b0;
      s1_tag    <= '0;
    end else if (en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_data   <= s1_data_d;
        s1_cnt    <= s1_cnt_d;
        s1_sticky <= s1_sticky_d;
        s1_err    <= s1_err_d;
        s1_unnorm <= s1_unnorm_d;
        s1_tag    <= i_tag;
      end
    end
  end

  logic [DATA_WIDTH-1:0] s2_data_d;
  logic                  s2_sticky_d;

  always_comb begin
    s2_data_d   = s1_data;
    s2_sticky_d = s1_sticky;
    if (s1_cnt[3]) begin
      s2_sticky_d = s2_sticky_d | (|s2_data_d[7:0]);
      s2_data_d   = {8'b0, s2_data_d[31:8]};
    end
    if (s1_cnt[2]) begin
      s2_sticky_d = s2_sticky_d | (|s2_data_d[3:0]);
      s2_data_d   = {4'b0, s2_data_d[31:4]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_cnt    <= 2'd0;
      s2_sticky <= 1'b0;
      s2_err    <= 1'b0;
      s2_unnorm <= 1'b0;
      s2_tag    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data   <= s2_data_d;
        s2_cnt    <= s1_cnt[1:0];
        s2_sticky <= s2_sticky_d;
        s2_err    <= s1_err;
        s2_unnorm <= s1_unnorm;
        s2_tag    <= s1_tag;
      end
    end
  end

  logic [DATA_WIDTH-1:0] s3_data_d;
  logic                  s3_sticky_d;

  always_comb begin
    s3_data_d   = s2_data;
    s3_sticky_d = s2_sticky;
    if (s2_cnt[1]) begin
      s3_sticky_d = s3_sticky_d | (|s3_data_d[1:0]);
      s3_data_d   = {2'b0, s3_data_d[31:2]};
    end
    if (s2_cnt[0]) begin
      s3_sticky_d = s3_sticky_d | s3_data_d[0];
      s3_data_d   = {1'b0, s3_data_d[31:1]};
    end
  end

  // Output registers keep their last result while the output is empty or stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_tag    <= '0;
      o_sticky <= 1'b0;
      o_error  <= 1'b0;
      o_unnorm <= 1'b0;
    end else if (en) begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_data   <= s3_data_d;
        o_tag    <= s2_tag;
        o_sticky <= s3_sticky_d;
        o_error  <= s2_err;
        o_unnorm <= s2_unnorm;
      end
    end
  end

endmodule

// File: tb/tb_clz_denormalizer.sv
// Bench for clz_denormalizer: directed cases, backpressure, mid-flight reset
// and random traffic, all scored against an arithmetic reference model.
module tb_clz_denormalizer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_mant;
  logic [5:0]  i_count;
  logic [3:0]  i_tag;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [3:0]  o_tag;
  logic        o_sticky;
  logic        o_error;
  logic        o_unnorm;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        sticky;
    logic        err;
    logic        unnorm;
  } exp_t;

  exp_t sb[$];
  exp_t head;

  clz_denormalizer #(.DATA_WIDTH(32), .CNT_WIDTH(6), .TAG_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mant(i_mant), .i_count(i_count), .i_tag(i_tag), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag), .o_sticky(o_sticky),
    .o_error(o_error), .o_unnorm(o_unnorm)
  );

  always #5 i_clk = ~i_clk;

  function automatic exp_t model(logic [31:0] mant, logic [5:0] cnt, logic [3:0] tag);
    exp_t e;
    logic [63:0] wide;
    logic [63:0] lost_mask;
    wide      = {32'b0, mant};
    lost_mask = (64'd1 << cnt) - 64'd1;
    e.data    = 32'(wide >> cnt);
    e.sticky  = (wide & lost_mask) != 64'd0;
    e.err     = cnt > 6'd32;
    e.unnorm  = (cnt < 6'd32) && !mant[31];
    e.tag     = tag;
    return e;
  endfunction

  function automatic int clz(logic [31:0] x);
    int n = 0;
    while (n < 32 && !x[31-n]) n++;
    return n;
  endfunction

  task automatic check_output(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // Scoreboard: inputs and outputs are sampled mid-cycle, before the edge that takes them.
  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
    end else begin
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          check_output("unexpected_output", 64'(o_valid), 64'd0);
        end else begin
          head = sb.pop_front();
          check_output("data",   64'(o_data),   64'(head.data));
          check_output("tag",    64'(o_tag),    64'(head.tag));
          check_output("sticky", 64'(o_sticky), 64'(head.sticky));
          check_output("error",  64'(o_error),  64'(head.err));
          check_output("unnorm", 64'(o_unnorm), 64'(head.unnorm));
        end
      end
      if (i_valid && o_ready) sb.push_back(model(i_mant, i_count, i_tag));
    end
  end

  task automatic apply_stimulus(input logic [31:0] mant, input logic [5:0] cnt,
                                input logic [3:0] tag);
    int n = 0;
    i_valid = 1'b1;
    i_mant  = mant;
    i_count = cnt;
    i_tag   = tag;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_ready && n < 200);
    if (!o_ready) check_output("accept_timeout", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check_output("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        rand_done;
    logic        found;
    logic [31:0] held_data;
    logic [3:0]  held_tag;
    logic [31:0] x;
    int          n;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_mant = '0; i_count = '0; i_tag = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    @(negedge i_clk);
    check_output("reset_o_valid",  64'(o_valid),  64'd0);
    check_output("reset_o_ready",  64'(o_ready),  64'd1);
    check_output("reset_o_data",   64'(o_data),   64'd0);
    check_output("reset_o_tag",    64'(o_tag),    64'd0);
    check_output("reset_o_sticky", 64'(o_sticky), 64'd0);
    check_output("reset_o_error",  64'(o_error),  64'd0);
    check_output("reset_o_unnorm", 64'(o_unnorm), 64'd0);

    // Latency: o_valid must rise exactly three cycles after the accept.
    @(posedge i_clk); #1;
    apply_stimulus(32'h8000_0000, 6'd0, 4'd1);
    @(negedge i_clk); check_output("latency_c1", 64'(o_valid), 64'd0);
    @(negedge i_clk); check_output("latency_c2", 64'(o_valid), 64'd0);
    @(negedge i_clk); check_output("latency_c3", 64'(o_valid), 64'd1);
    check_output("first_data", 64'(o_data), 64'h8000_0000);
    @(posedge i_clk); #1;

    apply_stimulus(32'h8000_0001, 6'd4,  4'd9);
    apply_stimulus(32'hF000_0000, 6'd31, 4'd10);
    apply_stimulus(32'h8000_0000, 6'd32, 4'd11);
    apply_stimulus(32'h8000_0000, 6'd40, 4'd12);
    apply_stimulus(32'h4000_0000, 6'd3,  4'd13);
    apply_stimulus(32'hFFFF_FFFF, 6'd63, 4'd14);
    apply_stimulus(32'h0000_0000, 6'd33, 4'd15);
    drain();

    // Backpressure: stall two cycles while tag 2 sits on the output.
    found = 1'b0;
    fork
      begin
        for (int t = 0; t < 8; t++)
          apply_stimulus($urandom, 6'($urandom_range(0, 32)), 4'(t));
      end
      begin
        for (int k = 0; k < 60 && !found; k++) begin
          @(posedge i_clk); #1;
          if (o_valid && o_tag == 4'd2) found = 1'b1;
        end
        check_output("stall_tag2_seen", 64'(found), 64'd1);
        if (found) begin
          i_ready   = 1'b0;
          held_data = o_data;
          held_tag  = o_tag;
          repeat (2) begin
            @(negedge i_clk);
            check_output("stall_o_ready", 64'(o_ready), 64'd0);
            check_output("stall_o_valid", 64'(o_valid), 64'd1);
            check_output("stall_o_data",  64'(o_data),  64'(held_data));
            check_output("stall_o_tag",   64'(o_tag),   64'd2);
            check_output("stall_tag_held", 64'(o_tag),  64'(held_tag));
            @(posedge i_clk); #1;
          end
          i_ready = 1'b1;
        end
      end
    join
    drain();

    // Mid-flight reset: tags 1..3 must never surface.
    apply_stimulus(32'h8000_0000, 6'd1, 4'd1);
    apply_stimulus(32'h8000_0000, 6'd2, 4'd2);
    i_valid = 1'b1; i_mant = 32'h8000_0000; i_count = 6'd3; i_tag = 4'd3;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_valid) n++;
    end
    check_output("post_reset_no_output", 64'(n), 64'd0);
    check_output("post_reset_o_data", 64'(o_data), 64'd0);
    @(posedge i_clk); #1;
    apply_stimulus(32'hC000_0000, 6'd5, 4'd6);
    drain();

    // Round trip through a software CLZ.
    for (int k = 0; k < 1000; k++) begin
      x = $urandom >> $urandom_range(0, 31);
      if (x == 32'd0) x = 32'd1;
      apply_stimulus(x << clz(x), 6'(clz(x)), 4'(k));
    end
    drain();

    // Random operands and counts under random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++)
          apply_stimulus($urandom, 6'($urandom_range(0, 63)), 4'($urandom));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clz_denormalizer.md
Name: clz_denormalizer

Overview:
- Decoder-side counterpart of the CLZ unit: takes a normalized mantissa and its leading-zero count, and reconstructs the original operand by a logical right shift.
- Sits in the execute-stage multicycle path beside the CLZ logic. The FP-style normalize/restore sequence uses CLZ on the way in and this block on the way out.
- Implemented as a 3-stage valid/ready pipeline: throughput 1 per cycle, latency 3 cycles.
- Reports bits lost to the shift, out-of-range counts, and non-normalized inputs.

Parameters:
- DATA_WIDTH, 32, operand width; only 32 is supported, and the stage split is fixed to it.
- CNT_WIDTH, 6, count width; a legal count is 0..32.
- TAG_WIDTH, 4, width of the opaque sideband tag carried alongside data.

Ports:
- i_clk  input  1  single clock; all state is updated on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream has a transaction.
- o_ready  output  1  block accepts a transaction this cycle.
- i_mant  input  32  normalized mantissa (bit 31 expected to be 1 when count < 32).
- i_count  input  6  leading-zero count to restore, in the CLZ result encoding.
- i_tag  input  TAG_WIDTH  sideband tag, returned unchanged.
- o_valid  output  1  result is available.
- i_ready  input  1  downstream accepts the result.
- o_data  output  32  restored value, i_mant >> i_count.
- o_tag  output  TAG_WIDTH  tag of the result.
- o_sticky  output  1  OR of all i_mant bits shifted out.
- o_error  output  1  i_count > 32.
- o_unnorm  output  1  i_count < 32 and i_mant[31] == 0.

Behaviour:
- Clock and reset: single clock i_clk; reset is synchronous and active-high on i_rst.
- Reset values:
  - All stage valid bits are 0.
  - o_valid, o_data, o_tag, o_sticky, o_error and o_unnorm are all 0.
  - o_ready is 1 in the first cycle after reset.
- Reset mid-operation: all in-flight transactions are dropped, with no partial output.
- Pipeline advance: global enable en = ~o_valid | i_ready.
  - o_ready = en, combinational.
  - Accept occurs when i_valid & o_ready.
  - When en = 0, every stage holds.
  - Bubbles are not collapsed.
- Stage 1 (registered):
  - Latch i_tag.
  - err = (i_count > 32); unnorm = (i_count < 32) & ~i_mant[31].
  - If i_count >= 32: data = 0, sticky = |i_mant, and the remaining shift is forced to 0.
  - Otherwise shift right by 16 when i_count[4] is set; sticky = OR of the bits dropped.
- Stage 2 (registered): shift by 8 if count[3], then by 4 if count[2]; sticky |= bits dropped.
- Stage 3 (output registers): shift by 2 if count[1], then by 1 if count[0]; sticky |= bits dropped.
- Shift rules: all shifts are logical (zero fill); no arithmetic sign extension.
- Latency: with i_ready held at 1, a transaction accepted in cycle t appears with o_valid = 1 in cycle t+3.
- Backpressure:
  - While o_valid & ~i_ready, all output ports hold stable and o_ready = 0.
  - Transaction order is strictly preserved.
- count == 32: o_data = 0, o_sticky = |i_mant, o_error = 0.
- count 33..63: o_error = 1, o_data = 0, o_sticky = |i_mant, o_unnorm = 0.
- count == 0: o_data = i_mant and o_sticky = 0.
- Simultaneous events: accept and output handshake in the same cycle is the normal full-throughput case; data advances in lockstep.
- Flag timing: o_error, o_unnorm and o_sticky are valid only when o_valid = 1; they travel with their transaction.

Test Plan:
- Reset, then mant=0x80000000 count=0 tag=1 -> 3 cycles later o_data=0x80000000, sticky=0, err=0, unnorm=0, tag=1.
- mant=0x80000001 count=4 -> o_data=0x08000000, sticky=1. Then mant=0xF0000000 count=31 -> o_data=0x00000001, sticky=1.
- count=32 mant=0x80000000 -> o_data=0, sticky=1, err=0. count=40 -> err=1, o_data=0. mant=0x40000000 count=3 -> unnorm=1, o_data=0x08000000.
- Stream tags 0..7 back-to-back; hold i_ready=0 for 2 cycles when tag 2 is at the output.
  - o_data/o_tag held stable, o_ready=0 while stalled.
  - All 8 results arrive in order, none lost or duplicated.
- Accept tags 1..3, assert i_rst for one cycle before any output -> o_valid=0 after reset, in-flight tags never appear; the next accepted transaction completes normally.
- Round-trip, 1000 random X != 0: n=CLZ(X), mant=X<<n -> o_data==X, sticky=0, err=0, unnorm=0.
